// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush sequencer for a 5-stage pipeline.
// Merges memory wait, multi-cycle MDU occupancy, load-use and branch-flush
// requests into one enable/flush pair per pipeline register. It also keeps a
// saturating count of the cycles in which the PC was frozen.
module pipeline_stall_controller #(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_use_stall,
    input  logic             branch_taken,
    input  logic             mdu_start,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             mdu_busy,
    output logic             mdu_done,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int CW = (MDU_LATENCY > 2) ? $clog2(MDU_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MDU_LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {RUN, MDU_BUSY} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          mdu_hold;

    // FSM state and MDU cycle counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state and MDU status. The release cycle ends the hold so EX/MEM
    // can capture the result. Release is deferred while MEM is stalled.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mdu_busy  = 1'b0;
        mdu_done  = 1'b0;
        case (state)
            RUN: begin
                if (mdu_start) begin
                    mdu_busy  = 1'b1;
                    state_nxt = MDU_BUSY;
                    cnt_nxt   = CNT_INIT;
                end
            end
            MDU_BUSY: begin
                mdu_busy = 1'b1;
                if (cnt > CNT_ONE) begin
                    // The MDU keeps computing even while MEM is stalled.
                    cnt_nxt = cnt - CNT_ONE;
                end else if (!mem_busy) begin
                    mdu_done  = 1'b1;
                    state_nxt = RUN;
                end
            end
        endcase
        // An op abandoned by reset never reports completion.
        if (reset) begin
            mdu_busy = 1'b0;
            mdu_done = 1'b0;
        end
    end

    assign mdu_hold = mdu_busy & ~mdu_done;

    // Enable/flush overrides, applied lowest priority first so higher ones win
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b1;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        if (branch_taken) begin
            if_id_flush = 1'b1;
        end
        if (load_use_stall) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            if_id_flush = 1'b0;   // branch operands invalid while ID held
            id_ex_flush = 1'b1;
        end
        if (mdu_hold) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_en     = 1'b0;
            id_ex_flush  = 1'b0; // ID/EX is held, not bubbled
            ex_mem_flush = 1'b1;
        end
        if (mem_busy) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_en     = 1'b0;
            id_ex_flush  = 1'b0;
            ex_mem_en    = 1'b0;
            ex_mem_flush = 1'b0; // EX/MEM must hold its contents for MEM
            mem_wb_flush = 1'b1;
        end
        // Reset clears every pipeline register.
        if (reset) begin
            pc_en        = 1'b1;
            if_id_en     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_en     = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_en    = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
        end
    end

    // Saturating count of cycles with a frozen PC
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (!pc_en && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: a table of single-cycle vectors,
// hand-written MDU and memory-wait sequences, and random stimulus. All of
// these are compared against a cycle-level behavioural model.
module tb_pipeline_stall_controller;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic reset, lu, br, ms, mb;

    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic ex_mem_en, ex_mem_flush, mem_wb_flush, mdu_busy, mdu_done;
    logic [15:0] sc;

    logic pc_en_s, if_id_en_s, if_id_flush_s, id_ex_en_s, id_ex_flush_s;
    logic ex_mem_en_s, ex_mem_flush_s, mem_wb_flush_s, mdu_busy_s, mdu_done_s;
    logic [3:0] sc_s;

    logic [9:0] dut_vec, dut_vec_s;
    assign dut_vec   = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                        ex_mem_en, ex_mem_flush, mem_wb_flush, mdu_busy, mdu_done};
    assign dut_vec_s = {pc_en_s, if_id_en_s, if_id_flush_s, id_ex_en_s, id_ex_flush_s,
                        ex_mem_en_s, ex_mem_flush_s, mem_wb_flush_s, mdu_busy_s, mdu_done_s};

    pipeline_stall_controller #(.MDU_LATENCY(LAT), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .load_use_stall(lu), .branch_taken(br),
        .mdu_start(ms), .mem_busy(mb),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .mdu_busy(mdu_busy), .mdu_done(mdu_done), .stall_cycles(sc)
    );

    pipeline_stall_controller #(.MDU_LATENCY(LAT), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .load_use_stall(lu), .branch_taken(br),
        .mdu_start(ms), .mem_busy(mb),
        .pc_en(pc_en_s), .if_id_en(if_id_en_s), .if_id_flush(if_id_flush_s),
        .id_ex_en(id_ex_en_s), .id_ex_flush(id_ex_flush_s), .ex_mem_en(ex_mem_en_s),
        .ex_mem_flush(ex_mem_flush_s), .mem_wb_flush(mem_wb_flush_s),
        .mdu_busy(mdu_busy_s), .mdu_done(mdu_done_s), .stall_cycles(sc_s)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: whether an op occupies EX past its start cycle, and how
    // many cycles have elapsed since that start cycle.
    bit in_op;
    int age;
    int cnt16, cnt4;

    typedef struct {
        logic       lu, br, mb;
        logic [9:0] exp;
    } vec_t;

    // Output vector the rules require for the current inputs and model state
    function automatic logic [9:0] model_out();
        logic busy, rel, hold, l, b, m;
        if (reset) return 10'b11111111_00;
        l    = lu;
        b    = br;
        m    = mb;
        busy = in_op || ms;
        rel  = in_op && (age >= LAT - 1) && !m;
        hold = busy && !rel;
        return {!(m | hold | l), !(m | hold | l), b & !l & !hold & !m,
                !(m | hold), l & !hold & !m, !m, hold & !m, m, busy, rel};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model, away from the active edge
    task automatic sample();
        logic [9:0] e;
        @(negedge clk);
        e = model_out();
        check("outputs", {22'd0, dut_vec}, {22'd0, e});
        check("outputs_sat_inst", {22'd0, dut_vec_s}, {22'd0, e});
        check("stall_cycles", {16'd0, sc}, cnt16);
        check("stall_cycles_sat", {28'd0, sc_s}, cnt4);
    endtask

    // Advance the model in step with the DUT clock edge
    task automatic tick();
        logic [9:0] e;
        e = model_out();
        @(posedge clk);
        if (reset) begin
            in_op = 0; age = 0; cnt16 = 0; cnt4 = 0;
        end else begin
            if (!e[9]) begin
                if (cnt16 < 65535) cnt16++;
                if (cnt4 < 15) cnt4++;
            end
            if (in_op) begin
                if (age >= LAT - 1 && !mb) in_op = 0;
                else age++;
            end else if (ms) begin
                in_op = 1;
                age   = 1;
            end
        end
        #1;
    endtask

    task automatic idle();
        lu = 0; br = 0; ms = 0; mb = 0;
    endtask

    vec_t tbl[8];
    int busy_n, flush_n, wbf_n, done_at, base;

    initial begin
        tbl[0] = '{0, 0, 0, 10'b11010100_00};
        tbl[1] = '{0, 1, 0, 10'b11110100_00};
        tbl[2] = '{1, 0, 0, 10'b00011100_00};
        tbl[3] = '{1, 1, 0, 10'b00011100_00};
        tbl[4] = '{0, 0, 1, 10'b00000001_00};
        tbl[5] = '{0, 1, 1, 10'b00000001_00};
        tbl[6] = '{1, 0, 1, 10'b00000001_00};
        tbl[7] = '{1, 1, 1, 10'b00000001_00};

        idle();
        in_op = 0; age = 0; cnt16 = 0; cnt4 = 0;
        reset = 1;
        #1;

        // Reset for two cycles: everything enabled and flushed
        sample(); check("reset_all_ones", {22'd0, dut_vec}, 32'b11111111_00); tick();
        sample(); check("reset_all_ones_2", {22'd0, dut_vec}, 32'b11111111_00); tick();
        reset = 0;
        sample();
        check("post_reset_vec", {22'd0, dut_vec}, 32'b11010100_00);
        check("post_reset_sc", {16'd0, sc}, 0);
        tick();

        // Single load-use cycle
        lu = 1;
        sample(); check("lus_vec", {22'd0, dut_vec}, 32'b00011100_00); tick();
        idle();
        sample(); check("lus_sc_one", {16'd0, sc}, 1); tick();

        // Load-use suppresses a same-cycle branch; branch re-presents next
        lu = 1; br = 1;
        sample();
        check("lus_br_if_id_flush", {31'd0, if_id_flush}, 0);
        check("lus_br_id_ex_flush", {31'd0, id_ex_flush}, 1);
        tick();
        lu = 0;
        sample(); check("br_if_id_flush", {31'd0, if_id_flush}, 1); tick();
        idle();

        // Vector table of combinational priorities from RUN
        foreach (tbl[i]) begin
            lu = tbl[i].lu; br = tbl[i].br; mb = tbl[i].mb;
            sample(); check($sformatf("table_%0d", i), {22'd0, dut_vec}, {22'd0, tbl[i].exp});
            tick();
        end
        idle();

        // One MDU op, no memory wait
        base = cnt16; busy_n = 0; flush_n = 0; done_at = -1;
        ms = 1;
        for (int c = 0; c < 6; c++) begin
            sample();
            busy_n  += int'(mdu_busy);
            flush_n += int'(ex_mem_flush);
            if (mdu_done) done_at = c;
            tick();
            ms = 0;
        end
        check("mdu_busy_cycles", busy_n, 4);
        check("mdu_flush_cycles", flush_n, 3);
        check("mdu_done_cycle", done_at, 3);
        check("mdu_stall_delta", {16'd0, sc} - base, 3);

        // MDU op with memory wait in cycles 1..5 (2nd hold cycle onward)
        busy_n = 0; wbf_n = 0; done_at = -1;
        ms = 1;
        for (int c = 0; c < 9; c++) begin
            mb = (c >= 1 && c <= 5);
            sample();
            wbf_n += int'(mem_wb_flush);
            if (mdu_done) done_at = c;
            tick();
            ms = 0;
        end
        idle();
        check("memwait_wb_flush_cycles", wbf_n, 5);
        check("memwait_done_cycle", done_at, 6);

        // Back-to-back MDU ops
        ms = 1;
        for (int c = 0; c < 10; c++) begin sample(); tick(); end
        idle();
        for (int c = 0; c < 4; c++) begin sample(); tick(); end

        // Saturation of the narrow counter
        lu = 1;
        for (int c = 0; c < 20; c++) begin sample(); tick(); end
        idle();
        sample(); check("sat_at_15", {28'd0, sc_s}, 15); tick();

        // Reset in the middle of an MDU op
        ms = 1; sample(); tick();
        ms = 0; sample(); tick();
        reset = 1; sample(); tick();
        reset = 0;
        done_at = 0; busy_n = 0;
        for (int c = 0; c < 6; c++) begin
            sample();
            done_at += int'(mdu_done);
            busy_n  += int'(mdu_busy);
            tick();
        end
        check("midop_reset_no_done", done_at, 0);
        check("midop_reset_no_busy", busy_n, 0);

        // Random stimulus against the model
        for (int c = 0; c < 600; c++) begin
            lu    = ($urandom_range(0, 3) == 0);
            br    = ($urandom_range(0, 2) == 0);
            ms    = ($urandom_range(0, 4) == 0);
            mb    = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 63) == 0);
            sample();
            tick();
        end
        reset = 0;
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
